divu_seq: RTL
=============

DIVU_SEQ -- requirements
Module: divu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand and result width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port arst_n, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port enable, input, 1, clock enable; when 0, all state and outputs hold.
REQ-005 SHALL have port start, input, 1, the request strobe, sampled on clk while enable=1.
REQ-006 SHALL have port dividend, input, WIDTH, unsigned numerator, captured on an accepted start.
REQ-007 SHALL have port divisor, input, WIDTH, unsigned denominator, captured on an accepted start.
REQ-008 SHALL have port busy, output, 1, high while a division is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when results become valid.
REQ-010 SHALL have port quotient, output, WIDTH, the result quotient.
REQ-011 SHALL have port remainder, output, WIDTH, the result remainder.
REQ-012 SHALL have port dbz, output, 1, divide-by-zero flag for the last result.

Function
REQ-013 SHALL implement unsigned restoring division, one quotient bit per enabled cycle, MSB first.
REQ-014 SHALL use a WIDTH+1-bit partial remainder: trial = {rem, next dividend bit} - divisor; if no borrow, rem <= trial and q bit = 1, else rem keeps the shifted value and q bit = 0.
REQ-015 SHALL use an FSM with states IDLE, RUN and DONE.
REQ-016 SHALL move from IDLE to RUN on an edge with start=1 and enable=1, and capture dividend and divisor on that edge.
REQ-017 SHALL stay in RUN for exactly WIDTH enabled cycles, then move to DONE.
REQ-018 SHALL assert done and load quotient and remainder in DONE for exactly one enabled cycle, then return to IDLE.
REQ-019 SHALL give latency as follows: done high after WIDTH+1 enabled rising edges following the accepting edge.
REQ-020 SHALL hold quotient, remainder and dbz stable from DONE until the next DONE.
REQ-021 SHALL assert busy in RUN and DONE and deassert it in IDLE.
REQ-022 SHALL ignore start while busy=1; an in-flight operation is never aborted or restarted.
REQ-023 SHALL accept start in the cycle immediately after DONE, so back-to-back operations run with no gap beyond IDLE.
REQ-024 SHALL, when enable=0 mid-RUN, freeze the iteration count and partial results; the operation resumes when enable=1.
REQ-025 SHALL, for divisor=0 in the iterative path, produce quotient = all ones and remainder = dividend.
REQ-026 SHALL, for dividend < divisor, produce quotient=0 and remainder=dividend.

Reset
REQ-027 SHALL, on arst_n=0 and regardless of clk, force the FSM to IDLE and set busy=0, done=0, quotient=0, remainder=0, dbz=0 and the internal counter to 0.
REQ-028 SHALL, on reset during RUN, discard the operation without asserting done.
REQ-029 SHALL, after arst_n deasserts, accept start on the first enabled rising edge.

Configuration
REQ-030 SHALL, when macro DIVU_SEQ_DBZ_FAST_EN is defined and divisor=0 at accept, skip RUN and enter DONE on the next enabled edge (done 1 cycle after accept), with quotient=all ones, remainder=dividend and dbz=1.
REQ-031 SHALL, when DIVU_SEQ_DBZ_FAST_EN is not defined, process divisor=0 through the full WIDTH-cycle RUN (REQ-025) and tie dbz to 0.

Verification (WIDTH=16)
REQ-032 SHALL verify: start with dividend=100, divisor=7 -> done 17 edges later, quotient=14, remainder=2, dbz=0.
REQ-033 SHALL verify: dividend=65535, divisor=1 -> quotient=65535, remainder=0; then dividend=5, divisor=9 started the cycle after done -> quotient=0, remainder=5.
REQ-034 SHALL verify: dividend=1234, divisor=0 -> quotient=65535, remainder=1234; with the macro, dbz=1 and done 1 edge after accept; without it, dbz=0 and done 17 edges after accept.
REQ-035 SHALL verify: start pulsed with dividend=50, divisor=5 at RUN cycle 3 of 100/7 -> result is still 14/2 and the 50/5 request is dropped.
REQ-036 SHALL verify: enable=0 for 4 cycles mid-RUN of 100/7 -> done 21 edges after accept, quotient=14, remainder=2.
REQ-037 SHALL verify: arst_n pulled low at RUN cycle 8 -> busy=0, done never pulses, and outputs=0 immediately; then 1000/10 -> quotient=100, remainder=0.

Source files
------------

// File: rtl/divu_seq.sv
`default_nettype none
// divu_seq: sequential unsigned restoring divider, one quotient bit per enabled clock.
// Optional macro DIVU_SEQ_DBZ_FAST_EN: divisor=0 bypasses iteration and raises dbz. Rev 1.0
module divu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;

`ifdef DIVU_SEQ_DBZ_FAST_EN
  logic fast;
`endif

  // dvd doubles as the quotient accumulator: dividend bits leave at the top, quotient bits enter at the bottom.
  always_comb begin
    shifted = {rem, dvd[WIDTH-1]};
    trial   = shifted - {2'b00, dvs};
    borrow  = trial[WIDTH+1];
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIVU_SEQ_DBZ_FAST_EN
      fast      <= 1'b0;
      dbz       <= 1'b0;
`endif
    end else if (enable) begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd   <= dividend;
            dvs   <= divisor;
            rem   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef DIVU_SEQ_DBZ_FAST_EN
            fast  <= (divisor == '0);
            if (divisor == '0) state <= DONE;
`endif
          end
        end
        RUN: begin
          rem <= borrow ? shifted[WIDTH:0] : trial[WIDTH:0];
          dvd <= {dvd[WIDTH-2:0], ~borrow};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
          quotient  <= dvd;
          remainder <= rem[WIDTH-1:0];
`ifdef DIVU_SEQ_DBZ_FAST_EN
          dbz <= fast;
          if (fast) begin
            quotient  <= '1;
            remainder <= dvd;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef DIVU_SEQ_DBZ_FAST_EN
  assign dbz = 1'b0;
`endif

endmodule
`default_nettype wire
